// File: rtl/chroma_key_pipe_if.sv
// ============================================================================
// chroma_key_pipe_if : pixel stream into and out of the chroma-key stage
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface chroma_key_pipe_if #(
  parameter int DW = 8
) ();
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] in_r;
  logic [DW-1:0] in_g;
  logic [DW-1:0] in_b;
  logic          out_valid;
  logic          out_sof;
  logic [DW-1:0] out_r;
  logic [DW-1:0] out_g;
  logic [DW-1:0] out_b;
  logic          out_keyed;

  // master: pixel source and sink around the stage; slave: the stage itself
  modport master (
    output in_valid, in_sof, in_r, in_g, in_b,
    input  out_valid, out_sof, out_r, out_g, out_b, out_keyed
  );
  modport slave (
    input  in_valid, in_sof, in_r, in_g, in_b,
    output out_valid, out_sof, out_r, out_g, out_b, out_keyed
  );
endinterface

`default_nettype wire

// File: rtl/chroma_key_pipe.sv
// ============================================================================
// chroma_key_pipe : 3-stage chroma-key scorer/filler with per-frame key count
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module chroma_key_pipe #(
  parameter int DW         = 8,
  parameter int CNTW       = 20,
  parameter int THRESH_RST = 82906
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  chroma_key_pipe_if.slave     px,
  input  wire logic            key_en,
  input  wire logic [1:0]      key_sel,
  input  wire logic [1:0]      mode,
  input  wire logic [DW-1:0]   bg_r,
  input  wire logic [DW-1:0]   bg_g,
  input  wire logic [DW-1:0]   bg_b,
  input  wire logic [3*DW-1:0] thresh,
  output logic [CNTW-1:0]      frame_key_count,
  output logic                 count_valid
);

  localparam logic [3*DW-1:0] c_thresh_init = (3*DW)'(THRESH_RST);
  localparam logic [CNTW-1:0] c_cnt_max     = '1;

  // ---------------- shadow configuration ----------------
  logic            r_sh_en;
  logic [1:0]      r_sh_sel;
  logic [1:0]      r_sh_mode;
  logic [DW-1:0]   r_sh_bg_r, r_sh_bg_g, r_sh_bg_b;
  logic [3*DW-1:0] r_sh_thresh;

  logic w_load;
  assign w_load = px.in_valid & px.in_sof;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_en     <= 1'b0;
      r_sh_sel    <= 2'd0;
      r_sh_mode   <= 2'd0;
      r_sh_bg_r   <= '0;
      r_sh_bg_g   <= '0;
      r_sh_bg_b   <= '0;
      r_sh_thresh <= c_thresh_init;
    end else if (w_load) begin
      r_sh_en     <= key_en;
      r_sh_sel    <= key_sel;
      r_sh_mode   <= mode;
      r_sh_bg_r   <= bg_r;
      r_sh_bg_g   <= bg_g;
      r_sh_bg_b   <= bg_b;
      r_sh_thresh <= thresh;
    end
  end

  // The sof pixel itself must already see the newly loaded configuration
  logic            w_cfg_en;
  logic [1:0]      w_cfg_sel;
  logic [1:0]      w_cfg_mode;
  logic [DW-1:0]   w_cfg_bg_r, w_cfg_bg_g, w_cfg_bg_b;
  logic [3*DW-1:0] w_cfg_thresh;

  assign w_cfg_en     = w_load ? key_en  : r_sh_en;
  assign w_cfg_sel    = w_load ? key_sel : r_sh_sel;
  assign w_cfg_mode   = w_load ? mode    : r_sh_mode;
  assign w_cfg_bg_r   = w_load ? bg_r    : r_sh_bg_r;
  assign w_cfg_bg_g   = w_load ? bg_g    : r_sh_bg_g;
  assign w_cfg_bg_b   = w_load ? bg_b    : r_sh_bg_b;
  assign w_cfg_thresh = w_load ? thresh  : r_sh_thresh;

  // ---------------- stage 1: channel select and differences ----------------
  logic [DW-1:0] w_k, w_a, w_b;

  always_comb begin
    w_k = px.in_g;
    w_a = px.in_r;
    w_b = px.in_b;
    case (w_cfg_sel)
      2'd1: begin
        w_k = px.in_b;
        w_a = px.in_r;
        w_b = px.in_g;
      end
      2'd2: begin
        w_k = px.in_r;
        w_a = px.in_g;
        w_b = px.in_b;
      end
      default: ;
    endcase
  end

  logic            r1_valid, r1_sof, r1_gt, r1_en;
  logic [DW-1:0]   r1_r, r1_g, r1_b, r1_k, r1_d1, r1_d2;
  logic [1:0]      r1_mode;
  logic [DW-1:0]   r1_bg_r, r1_bg_g, r1_bg_b;
  logic [3*DW-1:0] r1_thresh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid  <= 1'b0;
      r1_sof    <= 1'b0;
      r1_gt     <= 1'b0;
      r1_en     <= 1'b0;
      r1_r      <= '0;
      r1_g      <= '0;
      r1_b      <= '0;
      r1_k      <= '0;
      r1_d1     <= '0;
      r1_d2     <= '0;
      r1_mode   <= 2'd0;
      r1_bg_r   <= '0;
      r1_bg_g   <= '0;
      r1_bg_b   <= '0;
      r1_thresh <= '0;
    end else begin
      r1_valid  <= px.in_valid;
      r1_sof    <= px.in_valid & px.in_sof;
      // differences may wrap when k is not dominant; r1_gt masks them later
      r1_gt     <= (w_k > w_a) && (w_k > w_b);
      r1_en     <= w_cfg_en;
      r1_r      <= px.in_r;
      r1_g      <= px.in_g;
      r1_b      <= px.in_b;
      r1_k      <= w_k;
      r1_d1     <= w_k - w_a;
      r1_d2     <= w_k - w_b;
      r1_mode   <= w_cfg_mode;
      r1_bg_r   <= w_cfg_bg_r;
      r1_bg_g   <= w_cfg_bg_g;
      r1_bg_b   <= w_cfg_bg_b;
      r1_thresh <= w_cfg_thresh;
    end
  end

  // ---------------- stage 2: first partial product ----------------
  logic [2*DW-1:0] w_p1;
  assign w_p1 = {{DW{1'b0}}, r1_k} * {{DW{1'b0}}, r1_d1};

  logic            r2_valid, r2_sof, r2_gt, r2_en;
  logic [DW-1:0]   r2_r, r2_g, r2_b, r2_d2;
  logic [2*DW-1:0] r2_p1;
  logic [1:0]      r2_mode;
  logic [DW-1:0]   r2_bg_r, r2_bg_g, r2_bg_b;
  logic [3*DW-1:0] r2_thresh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid  <= 1'b0;
      r2_sof    <= 1'b0;
      r2_gt     <= 1'b0;
      r2_en     <= 1'b0;
      r2_r      <= '0;
      r2_g      <= '0;
      r2_b      <= '0;
      r2_d2     <= '0;
      r2_p1     <= '0;
      r2_mode   <= 2'd0;
      r2_bg_r   <= '0;
      r2_bg_g   <= '0;
      r2_bg_b   <= '0;
      r2_thresh <= '0;
    end else begin
      r2_valid  <= r1_valid;
      r2_sof    <= r1_sof;
      r2_gt     <= r1_gt;
      r2_en     <= r1_en;
      r2_r      <= r1_r;
      r2_g      <= r1_g;
      r2_b      <= r1_b;
      r2_d2     <= r1_d2;
      r2_p1     <= w_p1;
      r2_mode   <= r1_mode;
      r2_bg_r   <= r1_bg_r;
      r2_bg_g   <= r1_bg_g;
      r2_bg_b   <= r1_bg_b;
      r2_thresh <= r1_thresh;
    end
  end

  // ---------------- stage 3: score, compare, fill ----------------
  logic [3*DW-1:0] w_score;
  logic            w_keyed;
  logic [DW-1:0]   w_fill_r, w_fill_g, w_fill_b;

  assign w_score = r2_gt ? ({{DW{1'b0}}, r2_p1} * {{(2*DW){1'b0}}, r2_d2}) : '0;
  assign w_keyed = r2_en & (w_score > r2_thresh);

  always_comb begin
    w_fill_r = r2_r;
    w_fill_g = r2_g;
    w_fill_b = r2_b;
    case (r2_mode)
      2'd0: if (w_keyed) begin
        w_fill_r = '0;
        w_fill_g = '0;
        w_fill_b = '0;
      end
      2'd1: if (w_keyed) begin
        w_fill_r = r2_bg_r;
        w_fill_g = r2_bg_g;
        w_fill_b = r2_bg_b;
      end
      2'd2: begin
        w_fill_r = w_keyed ? '1 : '0;
        w_fill_g = w_keyed ? '1 : '0;
        w_fill_b = w_keyed ? '1 : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px.out_valid <= 1'b0;
      px.out_sof   <= 1'b0;
      px.out_r     <= '0;
      px.out_g     <= '0;
      px.out_b     <= '0;
      px.out_keyed <= 1'b0;
    end else begin
      px.out_valid <= r2_valid;
      px.out_sof   <= r2_sof;
      if (r2_valid) begin
        px.out_r     <= w_fill_r;
        px.out_g     <= w_fill_g;
        px.out_b     <= w_fill_b;
        px.out_keyed <= w_keyed;
      end
    end
  end

  // ---------------- per-frame keyed-pixel counter ----------------
  logic [CNTW-1:0] r_acc;
  logic            r_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc           <= '0;
      r_seen          <= 1'b0;
      frame_key_count <= '0;
      count_valid     <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (px.out_valid && px.out_sof) begin
        if (r_seen) begin
          frame_key_count <= r_acc;
          count_valid     <= 1'b1;
        end
        r_acc  <= {{(CNTW-1){1'b0}}, px.out_keyed};
        r_seen <= 1'b1;
      end else if (px.out_valid && px.out_keyed && (r_acc != c_cnt_max)) begin
        r_acc <= r_acc + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_chroma_key_pipe.sv
// ============================================================================
// tb_chroma_key_pipe : directed vector table plus hand sequences for chroma_key_pipe
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_chroma_key_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_en;
  logic [1:0]  key_sel;
  logic [1:0]  mode;
  logic [7:0]  bg_r, bg_g, bg_b;
  logic [23:0] thresh;
  logic [19:0] frame_key_count;
  logic        count_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pulse = 0;
  logic [19:0] last_cnt = '0;

  chroma_key_pipe_if #(.DW(8)) px ();

  chroma_key_pipe #(.DW(8), .CNTW(20), .THRESH_RST(82906)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .px              (px),
    .key_en          (key_en),
    .key_sel         (key_sel),
    .mode            (mode),
    .bg_r            (bg_r),
    .bg_g            (bg_g),
    .bg_b            (bg_b),
    .thresh          (thresh),
    .frame_key_count (frame_key_count),
    .count_valid     (count_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (count_valid === 1'b1) begin
      n_pulse  <= n_pulse + 1;
      last_cnt <= frame_key_count;
    end
  end

  typedef struct {
    logic [7:0]  r, g, b;
    logic        en;
    logic [1:0]  sel, md;
    logic [7:0]  br, bgg, bb;
    logic [23:0] th;
    logic [7:0]  er, eg, eb;
    logic        ek;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic [7:0] r, g, b, input logic en,
                              input logic [1:0] sel, md,
                              input logic [7:0] br, bgg, bb, input logic [23:0] th,
                              input logic [7:0] er, eg, eb, input logic ek);
    vec_t v;
    v.r = r; v.g = g; v.b = b; v.en = en; v.sel = sel; v.md = md;
    v.br = br; v.bgg = bgg; v.bb = bb; v.th = th;
    v.er = er; v.eg = eg; v.eb = eb; v.ek = ek;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {valid, sof, keyed, r, g, b}
  function automatic logic [63:0] outs();
    return {37'd0, px.out_valid, px.out_sof, px.out_keyed, px.out_r, px.out_g, px.out_b};
  endfunction

  function automatic logic [63:0] pack(input logic v, s, k, input logic [7:0] r, g, b);
    return {37'd0, v, s, k, r, g, b};
  endfunction

  // Present one pixel, then bubbles, and stop one step after its output edge
  task automatic send(input logic sof, input logic [7:0] r, g, b);
    @(posedge clk); #1;
    px.in_valid = 1'b1; px.in_sof = sof; px.in_r = r; px.in_g = g; px.in_b = b;
    @(posedge clk); #1;
    px.in_valid = 1'b0; px.in_sof = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic put(input logic v, sof, input logic [7:0] r, g, b);
    @(posedge clk); #1;
    px.in_valid = v; px.in_sof = sof; px.in_r = r; px.in_g = g; px.in_b = b;
  endtask

  task automatic cfg(input logic en, input logic [1:0] sel, md,
                     input logic [7:0] br, bgg, bb, input logic [23:0] th);
    key_en = en; key_sel = sel; mode = md; bg_r = br; bg_g = bgg; bg_b = bb; thresh = th;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    px.in_valid = 1'b0; px.in_sof = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    vecs[0]  = mk(0,200,0,     1,0,0, 0,0,0,    82906,    0,0,0,       1);
    vecs[1]  = mk(100,120,100, 1,0,0, 0,0,0,    82906,    100,120,100, 0);
    vecs[2]  = mk(100,120,100, 1,0,0, 0,0,0,    48000,    100,120,100, 0);
    vecs[3]  = mk(100,120,100, 1,0,0, 0,0,0,    47999,    0,0,0,       1);
    vecs[4]  = mk(200,100,50,  1,0,0, 0,0,0,    0,        200,100,50,  0);
    vecs[5]  = mk(200,100,50,  1,2,0, 0,0,0,    0,        0,0,0,       1);
    vecs[6]  = mk(200,100,50,  1,2,3, 0,0,0,    2999999,  200,100,50,  1);
    vecs[7]  = mk(200,100,50,  1,2,3, 0,0,0,    3000000,  200,100,50,  0);
    vecs[8]  = mk(0,200,0,     1,0,1, 10,20,30, 82906,    10,20,30,    1);
    vecs[9]  = mk(0,200,0,     1,0,2, 0,0,0,    82906,    255,255,255, 1);
    vecs[10] = mk(100,120,100, 1,0,2, 0,0,0,    82906,    0,0,0,       0);
    vecs[11] = mk(10,20,200,   1,1,0, 0,0,0,    0,        0,0,0,       1);
    vecs[12] = mk(10,20,200,   1,0,0, 0,0,0,    0,        10,20,200,   0);
    vecs[13] = mk(0,200,0,     0,0,0, 0,0,0,    0,        0,200,0,     0);
    vecs[14] = mk(0,200,0,     1,3,0, 0,0,0,    82906,    0,0,0,       1);
    vecs[15] = mk(0,255,0,     1,0,0, 0,0,0,    16581374, 0,0,0,       1);
    vecs[16] = mk(0,255,0,     1,0,0, 0,0,0,    16581375, 0,255,0,     0);
    vecs[17] = mk(200,200,200, 1,0,0, 0,0,0,    0,        200,200,200, 0);

    rst_n = 1'b0;
    px.in_valid = 1'b0; px.in_sof = 1'b0; px.in_r = '0; px.in_g = '0; px.in_b = '0;
    cfg(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {outs(), 20'(frame_key_count), count_valid}, 85'd0);
    rst_n = 1'b1;

    // Keying configured but no sof yet: stream must pass untouched
    cfg(1, 0, 0, 0, 0, 0, 0);
    send(0, 0, 200, 0);
    chk("pre_sof_passthrough", outs(), pack(1, 0, 0, 0, 200, 0));

    foreach (vecs[i]) begin
      cfg(vecs[i].en, vecs[i].sel, vecs[i].md, vecs[i].br, vecs[i].bgg, vecs[i].bb, vecs[i].th);
      send(1, vecs[i].r, vecs[i].g, vecs[i].b);
      chk($sformatf("vec%0d", i), outs(),
          pack(1, 1, vecs[i].ek, vecs[i].er, vecs[i].eg, vecs[i].eb));
    end

    // Mid-frame config change is ignored until the next sof
    cfg(1, 0, 0, 0, 0, 0, 82906);
    send(1, 0, 200, 0);
    chk("shadow_sof_mode0", outs(), pack(1, 1, 1, 0, 0, 0));
    cfg(1, 0, 1, 10, 20, 30, 82906);
    send(0, 0, 200, 0);
    chk("shadow_midframe_ignored", outs(), pack(1, 0, 1, 0, 0, 0));
    send(1, 0, 200, 0);
    chk("shadow_next_sof_mode1", outs(), pack(1, 1, 1, 10, 20, 30));
    @(posedge clk); #1;
    chk("bubble_hold", outs(), pack(0, 0, 1, 10, 20, 30));

    // Frame counting: 5 keyed of 8 with bubbles, first frame publishes nothing
    do_reset();
    cfg(1, 0, 0, 0, 0, 0, 82906);
    p0 = n_pulse;
    put(1, 1, 0, 200, 0);
    put(1, 0, 100, 120, 100);
    put(0, 0, 0, 0, 0);
    put(1, 0, 0, 200, 0);
    put(1, 0, 0, 200, 0);
    put(0, 0, 0, 0, 0);
    put(1, 0, 100, 120, 100);
    put(1, 0, 0, 200, 0);
    put(1, 0, 100, 120, 100);
    put(0, 0, 0, 0, 0);
    put(1, 0, 0, 200, 0);
    repeat (6) put(0, 0, 0, 0, 0);
    chk("first_frame_no_pulse", 64'(n_pulse - p0), 64'd0);
    put(1, 1, 0, 200, 0);
    repeat (8) put(0, 0, 0, 0, 0);
    chk("frameA_pulse_count", 64'(n_pulse - p0), 64'd1);
    chk("frameA_key_count", 64'(last_cnt), 64'd5);
    put(1, 1, 100, 120, 100);
    repeat (8) put(0, 0, 0, 0, 0);
    chk("frameB_pulse_count", 64'(n_pulse - p0), 64'd2);
    chk("frameB_key_count", 64'(last_cnt), 64'd1);

    // Reset in the middle of a frame with the pipeline full
    cfg(1, 0, 0, 0, 0, 0, 82906);
    p0 = n_pulse;
    put(1, 1, 0, 200, 0);
    put(1, 0, 0, 200, 0);
    put(1, 0, 0, 200, 0);
    put(1, 0, 0, 200, 0);
    rst_n = 1'b0;
    px.in_valid = 1'b0; px.in_sof = 1'b0;
    #1;
    chk("midframe_reset_outputs", {outs(), 20'(frame_key_count), count_valid}, 85'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cfg(1, 0, 0, 0, 0, 0, 0);
    send(0, 0, 200, 0);
    chk("post_reset_unkeyed", outs(), pack(1, 0, 0, 0, 200, 0));
    send(1, 0, 200, 0);
    chk("post_reset_sof_keyed", outs(), pack(1, 1, 1, 0, 0, 0));
    repeat (4) put(0, 0, 0, 0, 0);
    chk("post_reset_no_pulse", 64'(n_pulse - p0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/chroma_key_pipe.md
Name: chroma_key_pipe

Overview:
- Pipelined, parametrised chroma-key stage for the camera-to-VGA pixel path. It sits between the demosaic/colour stage and the display overlay.
- Scores each pixel against a selectable key channel (G, B or R). Keyed pixels are replaced according to a selectable fill mode.
- Key configuration is shadowed at frame start, so changes never tear mid-frame.
- Keyed pixels are counted per frame. The count is published at the next frame start for auto-threshold software.

Parameters:
- DW, 8, bits per colour channel.
- CNTW, 20, width of the per-frame keyed-pixel counter.
- THRESH_RST, 82906, reset value of the shadow threshold (0x143DA).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input pixel qualifier.
- in_sof  in  1  first pixel of frame; meaningful only with in_valid.
- in_r, in_g, in_b  in  DW each  input pixel channels.
- key_en  in  1  keying enable (shadowed).
- key_sel  in  2  key channel: 0=G, 1=B, 2=R, 3=G (shadowed).
- mode  in  2  fill mode for keyed pixels: 0=black, 1=bg colour, 2=mask, 3=pass-through with flag only (shadowed).
- bg_r, bg_g, bg_b  in  DW each  background colour for mode 1 (shadowed).
- thresh  in  3*DW  score threshold (shadowed).
- out_valid  out  1  output pixel qualifier.
- out_sof  out  1  delayed in_sof.
- out_r, out_g, out_b  out  DW each  output pixel channels.
- out_keyed  out  1  current output pixel was keyed.
- frame_key_count  out  CNTW  keyed-pixel count of the last completed frame.
- count_valid  out  1  one-cycle pulse when frame_key_count updates.

Behaviour:
- Reset (async assert, sync release): all outputs 0. Shadow config resets to key_en=0, key_sel=0, mode=0, bg=0, thresh=THRESH_RST. Accumulator 0; frame-seen flag 0.
- Shadow load: on the clk edge where in_valid & in_sof, the shadow register takes key_en, key_sel, mode, bg_* and thresh. That pixel and every later pixel use the new values. Mid-frame input changes are ignored. Before the first sof after reset, the pixel stream passes through unkeyed.
- Scoring: k = key channel; a and b = the other two channels.
  - If k>a and k>b: score = k*(k-a)*(k-b), unsigned, 3*DW bits, no overflow possible.
  - Otherwise score = 0.
  - keyed = key_en & (score > thresh). The compare is strict.
- Pipeline, fixed 3 cycles, no backpressure, advances every clock:
  - S1 registers diffs, k, the pixel, valid, sof and the config snapshot.
  - S2 registers k*(k-a).
  - S3 registers the final product, the compare and the fill mux into the outputs.
  - A pixel presented at edge N appears on the outputs after edge N+3.
  - Bubbles (in_valid=0) propagate as out_valid=0. While out_valid=0, out_r/g/b/keyed hold their last values.
- Fill when keyed:
  - mode0: output 0,0,0.
  - mode1: output bg_r, bg_g, bg_b.
  - mode2: output all-ones; non-keyed pixels in mode2 output 0 (binary matte).
  - mode3: pixel unchanged.
  - out_keyed=1 in every mode.
- Counter, evaluated at the output stage:
  - On out_valid & out_sof with frame-seen=1: frame_key_count <= acc, count_valid=1 for one cycle.
  - On that same edge acc <= out_keyed ? 1 : 0, and frame-seen <= 1.
  - Otherwise acc increments on out_valid & out_keyed and saturates at 2^CNTW-1.
  - The first sof after reset publishes nothing.
- Reset mid-frame: the pipeline flushes (out_valid=0 next cycle), the accumulator clears and the shadow config returns to reset values.

Test Plan:
- Reset, then an sof frame with key_en=1, key_sel=0, mode=0, thresh=82906, pixel (0,200,0) -> after 3 cycles out=(0,0,0), out_keyed=1 (score 8,000,000).
- Pixel (100,120,100), same config -> passed unchanged, out_keyed=0 (score 48,000). Repeat with thresh=48000 -> not keyed; with thresh=47999 -> keyed.
- Pixel (200,100,50), key_sel=0 -> score 0, unchanged. Same pixel with key_sel=2 and thresh=0 -> keyed (score 200*100*150 = 3,000,000).
- mode1 with bg=(10,20,30) on (0,200,0) -> out=(10,20,30). In mode2 a keyed pixel gives (255,255,255) and a non-keyed pixel gives (0,0,0). Change mode mid-frame -> no effect until the next in_sof.
- Frame A: 5 keyed of 8 pixels, with bubbles interleaved; then sof of frame B -> count_valid pulses once with frame_key_count=5. No pulse on the first frame after reset.
- Assert rst_n low mid-frame -> outputs 0 immediately. After release, pixels pass through unkeyed until the next sof.
